// File: rtl/jk_pkg.sv
// ============================================================================
// jk_pkg : mode encoding and the JK next-state rule used by every cell.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jk_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    JK    = 2'b01,
    LOAD  = 2'b10,
    COUNT = 2'b11
  } mode_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case ({j, k})
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      default: nq = ~q;
    endcase
    return nq;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_counter_bank_if.sv
// ============================================================================
// jk_counter_bank_if : control, data and status bundle of the JK counter bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface jk_counter_bank_if #(
  parameter int WIDTH = 8
);
  import jk_pkg::*;

  mode_e            mode;
  logic             up;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (output mode, up, j, k, d, input  q, tc, wrap);
  modport slave  (input  mode, up, j, k, d, output q, tc, wrap);

endinterface

`default_nettype wire

// File: rtl/jk_cell.sv
// ============================================================================
// jk_cell : single JK flip-flop with asynchronous active-high reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jk_cell
  import jk_pkg::*;
(
  input  wire  clk,
  input  wire  rst,
  input  wire  j,
  input  wire  k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= jk_next(q, j, k);
  end

endmodule

`default_nettype wire

// File: rtl/jk_counter_bank.sv
// ============================================================================
// jk_counter_bank : WIDTH-bit register of JK cells with hold/JK/load/count modes.
// Build option: JKC_SATURATE_EN makes COUNT saturate instead of wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2 ** WIDTH
) (
  input wire                clk,
  input wire                rst,
  jk_counter_bank_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] count_next;
  logic             count_wrap;
  logic [WIDTH-1:0] j_mask;
  logic [WIDTH-1:0] k_mask;
  logic             wrap_r;

  // Values above CNT_MAX can only arrive via LOAD/JK; counting up recovers to 0.
  always_comb begin
    count_next = q_vec;
    count_wrap = 1'b0;
    if (bus.up) begin
      if (q_vec == CNT_MAX) begin
        count_wrap = 1'b1;
`ifdef JKC_SATURATE_EN
        count_next = q_vec;
`else
        count_next = '0;
`endif
      end else if (q_vec > CNT_MAX) begin
        count_next = '0;
      end else begin
        count_next = q_vec + WIDTH'(1);
      end
    end else begin
      if (q_vec == '0) begin
        count_wrap = 1'b1;
`ifdef JKC_SATURATE_EN
        count_next = '0;
`else
        count_next = CNT_MAX;
`endif
      end else begin
        count_next = q_vec - WIDTH'(1);
      end
    end
  end

  always_comb begin
    j_mask = '0;
    k_mask = '0;
    case (bus.mode)
      JK: begin
        j_mask = bus.j;
        k_mask = bus.k;
      end
      LOAD: begin
        j_mask = bus.d;
        k_mask = ~bus.d;
      end
      COUNT: begin
        j_mask = q_vec ^ count_next;
        k_mask = q_vec ^ count_next;
      end
      default: begin
        j_mask = '0;
        k_mask = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_mask[i]),
      .k   (k_mask[i]),
      .q   (q_vec[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_r <= 1'b0;
    else     wrap_r <= (bus.mode == COUNT) && count_wrap;
  end

  assign bus.q    = q_vec;
  assign bus.wrap = wrap_r;
  assign bus.tc   = bus.up ? (q_vec == CNT_MAX) : (q_vec == '0);

endmodule

`default_nettype wire
